// File: rtl/uart_cfg_pkg.sv
// Shared constants and types for the UART baud/tick generation blocks.
// The divisor is an integer part plus a fraction in 1/2^FRAC_W units.
package uart_cfg_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DIV_W_DEFAULT      = 16;
  localparam int FRAC_W_DEFAULT     = 8;
  localparam int INT_DEFAULT        = 651;
  localparam int FRAC_DEFAULT       = 11;
  localparam int OS_CNT_W = $clog2(OVERSAMPLE_DEFAULT);

  typedef struct packed {
    logic [DIV_W_DEFAULT-1:0]  int_part;
    logic [FRAC_W_DEFAULT-1:0] frac_part;
  } div_cfg_t;

endpackage

// File: rtl/os_prescaler.sv
// Fractional-N prescaler: one oversample tick every div_int (+carry)
// clocks, with the fraction spread over periods by an accumulator.
module os_prescaler #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              due,
  output logic              os_tick
);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              tick_q, tick_d;
  logic [DIV_W:0]    last;

  // Extra bit keeps div_int + carry from wrapping at the top of range.
  assign last = {1'b0, div_int}
              + (DIV_W+1)'(carry_q)
              - (DIV_W+1)'(1);

  assign due = en && !sync
            && ({1'b0, cnt_q} == last);

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    tick_d  = 1'b0;
    if (sync) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (due) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      {carry_d, acc_d} = {1'b0, acc_q}
                       + {1'b0, div_frac};
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      tick_q  <= tick_d;
    end
  end

  assign os_tick = tick_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: oversample, mid-bit and end-of-bit enables
// with a shadowed divisor that only takes effect on bit boundaries.
module baud_tick_gen
  import uart_cfg_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEFAULT,
  parameter int FRAC_W       = FRAC_W_DEFAULT,
  parameter int OVERSAMPLE   = OVERSAMPLE_DEFAULT,
  parameter int DEFAULT_INT  = INT_DEFAULT,
  parameter int DEFAULT_FRAC = FRAC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [DIV_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_busy,
  output logic              cfg_err,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int OCW = $clog2(OVERSAMPLE);
  localparam logic [OCW-1:0] OS_LAST = OCW'(OVERSAMPLE - 1);
  localparam logic [OCW-1:0] OS_MID  = OCW'(OVERSAMPLE / 2 - 1);

  typedef struct packed {
    logic [DIV_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac_part;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    int_part:  DIV_W'(DEFAULT_INT),
    frac_part: FRAC_W'(DEFAULT_FRAC)
  };

  cfg_t           act_q, act_d;
  cfg_t           sh_q, sh_d;
  cfg_t           wr_cfg;
  logic           pend_q, pend_d;
  logic           err_q, err_d;
  logic [OCW-1:0] os_cnt_q, os_cnt_d;
  logic           mid_q, mid_d;
  logic           bit_q, bit_d;
  logic           low_int;
  logic           due;
  logic           apply;

  assign low_int = cfg_int < DIV_W'(2);
  assign wr_cfg.int_part  = low_int ? DIV_W'(2) : cfg_int;
  assign wr_cfg.frac_part = cfg_frac;

  // bit_q marks the first cycle of a new bit, so a swap here
  // never shortens or stretches the bit that just ended.
  assign apply = pend_q && (bit_q || sync || !en);

  os_prescaler #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_pre (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .div_int  (act_q.int_part),
    .div_frac (act_q.frac_part),
    .due      (due),
    .os_tick  (os_tick)
  );

  always_comb begin
    act_d    = act_q;
    sh_d     = sh_q;
    pend_d   = pend_q;
    err_d    = err_q;
    os_cnt_d = os_cnt_q;
    mid_d    = 1'b0;
    bit_d    = 1'b0;
    if (apply) begin
      act_d  = sh_q;
      pend_d = 1'b0;
    end
    if (cfg_wr) begin
      sh_d   = wr_cfg;
      pend_d = 1'b1;
      err_d  = err_q | low_int;
    end
    if (sync) begin
      os_cnt_d = '0;
    end else if (due) begin
      mid_d = (os_cnt_q == OS_MID);
      bit_d = (os_cnt_q == OS_LAST);
      os_cnt_d = bit_d ? '0
               : os_cnt_q + OCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      act_q    <= CFG_RST;
      sh_q     <= CFG_RST;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      os_cnt_q <= '0;
      mid_q    <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      act_q    <= act_d;
      sh_q     <= sh_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      os_cnt_q <= os_cnt_d;
      mid_q    <= mid_d;
      bit_q    <= bit_d;
    end
  end

  assign cfg_busy = pend_q;
  assign cfg_err  = err_q;
  assign mid_tick = mid_q;
  assign bit_tick = bit_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: expected tick times queued by the driver,
// popped and compared by a negedge monitor.
module tb_baud_tick_gen;

  logic        clk;
  logic        reset;
  logic        en;
  logic        sync;
  logic        cfg_wr;
  logic [15:0] cfg_int;
  logic [7:0]  cfg_frac;
  logic        cfg_busy;
  logic        cfg_err;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;

  baud_tick_gen dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .cfg_wr   (cfg_wr),
    .cfg_int  (cfg_int),
    .cfg_frac (cfg_frac),
    .cfg_busy (cfg_busy),
    .cfg_err  (cfg_err),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  typedef struct {
    int t;
    bit mid;
    bit bt;
  } tick_t;

  typedef struct {
    int cint;
    int cfrac;
    int n;
    int eint;
  } vec_t;

  tick_t exp_q[$];
  int    seen[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    tick_t e;
    if (os_tick === 1'b1) begin
      seen.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tick_unexp: tick at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.t != cyc || e.mid !== mid_tick || e.bt !== bit_tick) begin
          errors++;
          $display("FAIL tick: got cycle %0d mid %0b bit %0b, required cycle %0d mid %0b bit %0b",
                   cyc, mid_tick, bit_tick, e.t, e.mid, e.bt);
        end
      end
    end else begin
      if (mid_tick !== 1'b0 || bit_tick !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL orphan: mid %0b bit %0b at cycle %0d, required 0 without os_tick",
                 mid_tick, bit_tick, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
        checks++;
        errors++;
        $display("FAIL tick_missed: no tick by cycle %0d, required one at %0d",
                 cyc, exp_q[0].t);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  // Ticks after a restart at edge `start`; period k uses the carry
  // produced by the accumulator update at tick k-1.
  task automatic push_ticks(input int start, input int p_int,
                            input int p_frac, input int n, input int os0);
    int t;
    int acc;
    int cy;
    int os;
    tick_t e;
    t = start;
    acc = 0;
    cy = 0;
    os = os0;
    for (int k = 0; k < n; k++) begin
      t = t + p_int + cy;
      acc = acc + p_frac;
      cy = (acc >= 256) ? 1 : 0;
      acc = acc % 256;
      e.t = t;
      e.mid = (os == 7);
      e.bt = (os == 15);
      exp_q.push_back(e);
      os = (os == 15) ? 0 : os + 1;
    end
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) return;
      step();
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d ticks outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic cfg_sync(input int ci, input int cf, output int s);
    cfg_int = 16'(ci);
    cfg_frac = 8'(cf);
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    chk("busy_rise", 32'(cfg_busy), 1);
    sync = 1'b1;
    s = cyc + 1;
    step();
    sync = 1'b0;
    chk("busy_fall", 32'(cfg_busy), 0);
  endtask

  task automatic first_gap(input string nm, input int from, input int want);
    if (seen.size() == 0) chk(nm, 0, 32'(want));
    else chk(nm, 32'(seen[0] - from), 32'(want));
  endtask

  vec_t tbl[4];
  int   r0;
  int   s;
  int   e0;
  int   eb;
  int   t2;
  bit   bad;

  initial begin
    tbl[0] = '{cint: 3, cfrac: 128, n: 24, eint: 3};
    tbl[1] = '{cint: 5, cfrac: 200, n: 24, eint: 5};
    tbl[2] = '{cint: 2, cfrac: 0,   n: 20, eint: 2};
    tbl[3] = '{cint: 4, cfrac: 0,   n: 40, eint: 4};

    reset = 1'b0;
    en = 1'b0;
    sync = 1'b0;
    cfg_wr = 1'b0;
    cfg_int = '0;
    cfg_frac = '0;
    repeat (3) step();
    chk("rst_out", 32'({os_tick, mid_tick, bit_tick, cfg_busy, cfg_err}), 0);

    // defaults 651 + 11/256: 32 periods contain exactly one long one
    reset = 1'b1;
    en = 1'b1;
    r0 = cyc;
    seen.delete();
    push_ticks(r0, 651, 11, 33, 0);
    wait_empty(22000);
    first_gap("first_tick", r0, 651);
    if (seen.size() == 33) chk("span32", 32'(seen[32] - seen[0]), 20833);
    else chk("span_cnt", 32'(seen.size()), 33);

    for (int i = 0; i < 4; i++) begin
      seen.delete();
      cfg_sync(tbl[i].cint, tbl[i].cfrac, s);
      push_ticks(s, tbl[i].eint, tbl[i].cfrac, tbl[i].n, 0);
      wait_empty(2000);
      first_gap("sync_first", s, tbl[i].eint);
    end

    // deferred update: written 8 ticks into a bit at P=4
    e0 = cyc;
    eb = e0 + 32;
    push_ticks(e0, 4, 0, 8, 8);
    push_ticks(eb, 10, 0, 20, 0);
    cfg_int = 16'd10;
    cfg_frac = 8'd0;
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40 && cyc < eb; i++) begin
      if (cfg_busy !== 1'b1) bad = 1'b1;
      step();
    end
    chk("busy_hold", 32'(bad), 0);
    chk("busy_at_bit", 32'(cfg_busy), 1);
    step();
    chk("busy_after_bit", 32'(cfg_busy), 0);
    wait_empty(400);

    // sync lands on the edge where bit_tick would fire
    push_ticks(cyc, 10, 0, 11, 4);
    wait_empty(200);
    t2 = cyc;
    for (int i = 0; i < 20 && cyc < t2 + 9; i++) step();
    sync = 1'b1;
    s = cyc + 1;
    step();
    sync = 1'b0;
    chk("sync_quiet", 32'({os_tick, mid_tick, bit_tick}), 0);
    seen.delete();
    push_ticks(s, 10, 0, 16, 0);
    wait_empty(300);
    first_gap("sync_due_first", s, 10);

    // clamp and overwrite while pending
    cfg_int = 16'd1;
    cfg_frac = 8'd0;
    cfg_wr = 1'b1;
    step();
    chk("err_set", 32'(cfg_err), 1);
    chk("busy_clamp", 32'(cfg_busy), 1);
    cfg_int = 16'd0;
    step();
    cfg_wr = 1'b0;
    sync = 1'b1;
    s = cyc + 1;
    step();
    sync = 1'b0;
    push_ticks(s, 2, 0, 20, 0);
    wait_empty(100);
    chk("err_sticky", 32'(cfg_err), 1);

    // en low for 37 cycles, three cycles into a 7-cycle period
    seen.delete();
    cfg_sync(7, 0, s);
    push_ticks(s, 7, 0, 2, 0);
    wait_empty(50);
    repeat (3) step();
    push_ticks(s + 14 + 37, 7, 0, 4, 2);
    en = 1'b0;
    repeat (37) step();
    en = 1'b1;
    wait_empty(100);
    if (seen.size() >= 3) chk("en_shift", 32'(seen[2] - seen[1]), 44);
    else chk("en_cnt", 32'(seen.size()), 6);

    // reset mid-bit with a configuration pending
    cfg_int = 16'd9;
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    chk("busy_pre_rst", 32'(cfg_busy), 1);
    reset = 1'b0;
    step();
    chk("rst_mid", 32'({os_tick, mid_tick, bit_tick, cfg_busy, cfg_err}), 0);
    reset = 1'b1;
    r0 = cyc;
    seen.delete();
    push_ticks(r0, 651, 11, 3, 0);
    wait_empty(2100);
    first_gap("rst_default", r0, 651);
    chk("busy_post_rst", 32'(cfg_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

- Parametrised baud-rate tick generator for the UART communication module; successor to the fixed 868-count TX divider.
- Produces three single-cycle enable pulses from `clk`: an oversample tick, a bit tick and a mid-bit tick. Nothing in this block is a derived clock.
- The divisor has integer and fractional parts, is reprogrammable at runtime and updates glitch-free.
- A `sync` input lets the receiver realign the phase on start-bit detection. One instance feeds TX and one feeds RX.

## Interface
- `DIV_W`, 16: integer divisor width.
- `FRAC_W`, 8: fractional divisor width.
- `OVERSAMPLE`, 16: oversample ticks per bit. Must be even and ≥ 2.
- `DEFAULT_INT`, 651: integer divisor after reset (100 MHz / 153600).
- `DEFAULT_FRAC`, 11: fractional divisor after reset, in units of 1/2^FRAC_W.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  count enable. While low, all counters hold and no ticks are produced.
- `sync`  in  1  phase restart.
- `cfg_wr`  in  1  one-cycle strobe that captures `cfg_int`/`cfg_frac`.
- `cfg_int`  in  DIV_W  new integer divisor.
- `cfg_frac`  in  FRAC_W  new fractional divisor.
- `cfg_busy`  out  1  a captured configuration is waiting to be applied.
- `cfg_err`  out  1  sticky flag: a `cfg_int` < 2 was written. Cleared only by reset.
- `os_tick`  out  1  oversample pulse.
- `mid_tick`  out  1  pulse at the middle of each bit.
- `bit_tick`  out  1  pulse at the end of each bit.

## Operation
- **State:**
  - `cnt` (DIV_W bits)
  - `os_cnt` (clog2(OVERSAMPLE) bits)
  - `acc` (FRAC_W bits)
  - `carry` (1 bit)
  - active `div_int`/`div_frac`
  - shadow `sh_int`/`sh_frac`
  - `pend` (1 bit)
- **Oversample period:** P = `div_int` + `carry`. The average period is `div_int` + `div_frac`/2^FRAC_W clocks.
- **Enabled cycle, `sync` low:**
  - If `cnt` == P−1:
    - `cnt` ← 0
    - `os_tick` ← 1
    - {`carry`, `acc`} ← `acc` + `div_frac`
    - `os_cnt` ← (`os_cnt` == OVERSAMPLE−1) ? 0 : `os_cnt`+1
  - Otherwise: `cnt` ← `cnt`+1 and `os_tick` ← 0.
- **`mid_tick`:** asserted together with the `os_tick` on which `os_cnt` moves from OVERSAMPLE/2−1 to OVERSAMPLE/2.
- **`bit_tick`:** asserted together with the `os_tick` on which `os_cnt` wraps to 0.
- **`sync` high:**
  - `cnt`, `os_cnt`, `acc` and `carry` are cleared.
  - All ticks are 0 that cycle.
  - `sync` overrides `en` and any tick due in the same cycle.
  - A pending configuration is applied in the same cycle.
- **Configuration write (`cfg_wr`):**
  - Shadow registers are loaded and `pend` ← 1.
  - A `cfg_int` < 2 is clamped to 2 and sets `cfg_err`.
  - A second `cfg_wr` while `pend` is set overwrites the shadow (last write wins).
- **Applying a pending configuration:** active ← shadow and `pend` ← 0. This happens at the first of:
  - a cycle with `bit_tick` asserted;
  - a cycle with `sync` high;
  - any cycle with `en` low.
- **`cfg_wr` coinciding with an apply:** the new value is captured into the shadow and stays pending. The older shadow is applied.
- **No mid-bit change:** the period never changes inside a bit while `en` is high.

## Timing
- **Reset values** (while `reset` is low at a rising edge):
  - all ticks 0
  - `cfg_busy` 0, `cfg_err` 0
  - `cnt`, `os_cnt`, `acc`, `carry` = 0
  - active and shadow divisors = defaults
- **Reset mid-operation:** discards pending configuration and phase.
- **Tick outputs:**
  - Registered, each high for exactly one cycle.
  - `bit_tick` and `mid_tick` are always coincident with an `os_tick`.
- **First tick latency:** with `en` held high from the first edge after reset release, the first `os_tick` is high in clock cycle P (1-indexed). Subsequent ticks follow every P clocks.
- **After `sync`:** the first `os_tick` comes P cycles after the `sync` cycle.
- **`cfg_busy`:** rises the cycle after `cfg_wr` and falls the cycle after the apply.
- **`en` gating:** `en` low freezes phase exactly. Resuming continues from the held `cnt`, with no extra or lost tick.

## Structure
- **Package `uart_cfg_pkg`:**
  - constants `OVERSAMPLE_DEFAULT`, `DIV_W_DEFAULT`, `FRAC_W_DEFAULT`
  - localparam `OS_CNT_W = $clog2(OVERSAMPLE)`
  - `div_cfg_t` struct {int, frac}
- **Sub-module `os_prescaler`:**
  - Contains `cnt`, `acc` and `carry`.
  - Inputs: `en`, `sync`, `div_int`, `div_frac`. Output: `os_tick`.
  - The top level adds `os_cnt`, the mid/bit decode and the shadow/apply logic.

## Test plan
- **Default after reset:**
  - Stimulus: `en`=1, `div_int`=651, `div_frac`=11, measure over 256 os_ticks.
  - Required: total span = 166,667 clocks (exactly 11 periods of 652, the rest 651).
  - Required: `bit_tick` every 16th `os_tick`, `mid_tick` on the 8th.
- **Integer-only divisor:**
  - Stimulus: `cfg_int`=4, `cfg_frac`=0, then `sync`.
  - Required: `os_tick` every 4 cycles, `bit_tick` every 64, first `os_tick` 4 cycles after `sync`.
- **Deferred configuration:**
  - Stimulus: `cfg_wr` with `cfg_int`=10 mid-bit while `en`=1.
  - Required: `cfg_busy`=1 until the `bit_tick` cycle; the old period persists until then, and the new period of 10 starts immediately after.
- **Sync over due tick:**
  - Stimulus: assert `sync` in the cycle `bit_tick` would fire.
  - Required: no tick that cycle, counters are zero, the next `os_tick` comes P cycles later.
- **Clamp and overwrite:**
  - Stimulus: `cfg_wr` `cfg_int`=1, then `cfg_wr` `cfg_int`=0 while pending.
  - Required: `cfg_err`=1 (sticky); the applied `div_int` is 2 and `os_tick` fires every 2 cycles.
- **Enable gating and reset:**
  - Stimulus: drop `en` for 37 cycles mid-period.
  - Required: the tick grid shifts by exactly 37 cycles.
  - Stimulus: pull `reset` low mid-bit.
  - Required: all outputs are 0 on the next edge and the defaults are restored.
